// File: rtl/mem_resp_mc.sv
`default_nettype none
// ============================================================================
//  Module   : mem_resp_mc
//  Brief    : Wait-state word memory responder for a multicycle CPU port.
//             One request at a time, programmable latency, one-cycle ready.
//  Revision : 1.0  initial release
// ============================================================================
module mem_resp_mc #(
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [3:0] c_count_init = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         c_zero_lat   = (LATENCY == 0);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nx;
    logic [3:0]    r_count;

    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_accept;
    logic          w_enter_done;
    logic          w_op_we;
    logic [31:0]   w_op_addr;
    logic [31:0]   w_op_wdata;
    logic [3:0]    w_op_be;
    logic [AW-1:0] w_idx;
    logic          w_hi_bad;
    logic          w_bad;
    logic          w_ready;
    logic          w_busy;

    logic [31:0]   r_mem [0:(1<<AW)-1];

    assign w_accept = (r_state == c_idle) && req;

    // With zero latency the access completes on the accept edge, so the
    // operation is taken straight from the inputs rather than the captures.
    assign w_op_we    = (r_state == c_idle) ? we    : r_we;
    assign w_op_addr  = (r_state == c_idle) ? addr  : r_addr;
    assign w_op_wdata = (r_state == c_idle) ? wdata : r_wdata;
    assign w_op_be    = (r_state == c_idle) ? be    : r_be;

    assign w_idx = w_op_addr[AW+1:2];

    generate
        if (AW < 30) begin : g_hi_chk
            assign w_hi_bad = |w_op_addr[31:AW+2];
        end else begin : g_hi_none
            assign w_hi_bad = 1'b0;
        end
    endgenerate

    assign w_bad        = (w_op_addr[1:0] != 2'b00) || w_hi_bad;
    assign w_enter_done = (r_state != c_done) && (w_state_nx == c_done);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_idle: begin
                if (req) begin
                    w_state_nx = c_zero_lat ? c_done : c_wait;
                end
            end
            c_wait: begin
                if (r_count == 4'd0) begin
                    w_state_nx = c_done;
                end
            end
            c_done:  w_state_nx = c_idle;
            default: w_state_nx = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            c_idle: begin
                w_ready = 1'b0;
                w_busy  = 1'b0;
            end
            c_wait: begin
                w_ready = 1'b0;
                w_busy  = 1'b1;
            end
            c_done: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_be    <= be;
                r_count <= c_count_init;
            end else if ((r_state == c_wait) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end

            if (w_enter_done) begin
                if (w_bad) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end else if (w_op_we) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                end else begin
                    r_rdata <= r_mem[w_idx];
                    r_err   <= 1'b0;
                end
            end
        end
    end

    // Storage is never cleared; the rst gate drops a commit racing a reset.
    always_ff @(posedge clk) begin
        if (w_enter_done && w_op_we && !w_bad && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (w_op_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready = w_ready;
    assign busy  = w_busy;
    assign rdata = r_rdata;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_resp_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_resp_mc
//  Brief    : Three responders (latency 2, 0, 15) driven from shared stimulus
//             and compared against a word-array reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_resp_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  en;
    logic [2:0]  req_v;
    logic [2:0]  ready_v;
    logic [2:0]  err_v;
    logic [2:0]  busy_v;
    logic [31:0] rdata_v [3];

    int          lat [3] = '{2, 0, 15};
    logic [31:0] model [256];
    logic [31:0] last_rdata;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign req_v = {3{req}} & en;

    mem_resp_mc #(.AW(8), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready_v[0]), .rdata(rdata_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );
    mem_resp_mc #(.AW(8), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready_v[1]), .rdata(rdata_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );
    mem_resp_mc #(.AW(8), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .req(req_v[2]), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready_v[2]), .rdata(rdata_v[2]), .err(err_v[2]), .busy(busy_v[2])
    );

    // One complete transaction on every enabled responder, checked cycle by cycle.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input string name);
        logic [31:0] exp_r;
        logic        exp_e;
        logic [31:0] merged;
        logic [2:0]  seen;
        exp_e = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
        exp_r = 32'd0;
        if (!exp_e) begin
            if (w) begin
                merged = model[a[9:2]];
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) merged[8*k +: 8] = d[8*k +: 8];
                end
                model[a[9:2]] = merged;
            end else begin
                exp_r = model[a[9:2]];
            end
        end
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk);
        #1;
        req = 1'b0;
        seen = 3'b000;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (en[i]) begin
                    checks++;
                    if (busy_v[i] !== ((n <= lat[i]) ? 1'b1 : 1'b0)) begin
                        failures++;
                        $display("FAIL %s busy dut%0d cycle=%0d got=%b exp=%b",
                                 name, i, n, busy_v[i], (n <= lat[i]));
                    end
                    if (ready_v[i] === 1'b1) begin
                        checks++;
                        if (n != lat[i]) begin
                            failures++;
                            $display("FAIL %s ready_latency dut%0d got=%0d exp=%0d",
                                     name, i, n, lat[i]);
                        end
                        checks++;
                        if (rdata_v[i] !== exp_r || err_v[i] !== exp_e) begin
                            failures++;
                            $display("FAIL %s data dut%0d got=%h/%b exp=%h/%b",
                                     name, i, rdata_v[i], err_v[i], exp_r, exp_e);
                        end
                        if (i == 0) last_rdata = rdata_v[i];
                        seen[i] = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                checks++;
                if (seen[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL %s no_ready dut%0d got=%b exp=1", name, i, seen[i]);
                end
            end
        end
    endtask

    task automatic check_idle_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                checks++;
                if (ready_v[i] !== 1'b0 || busy_v[i] !== 1'b0 ||
                    rdata_v[i] !== 32'd0 || err_v[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL %s dut%0d got r=%b b=%b d=%h e=%b exp all zero",
                             name, i, ready_v[i], busy_v[i], rdata_v[i], err_v[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        en = 3'b111; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        rst = 1'b1;
        #2;
        check_idle_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset_held");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_init();
        for (int w = 0; w < 256; w++) begin
            txn(1'b1, 32'(w) << 2, $urandom, 4'hF, "init");
        end
    endtask

    task automatic test_directed();
        txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, "wr_100");
        txn(1'b0, 32'h100, 32'd0, 4'h0, "rd_100");
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL raw_100 got=%h exp=deadbeef", last_rdata);
        end
        txn(1'b1, 32'h40, 32'h11223344, 4'hF, "wr_40");
        txn(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, "wr_40_be");
        txn(1'b0, 32'h40, 32'd0, 4'h0, "rd_40");
        checks++;
        if (last_rdata !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL merge_40 got=%h exp=11bb33dd", last_rdata);
        end
    endtask

    task automatic test_bad_access();
        txn(1'b0, 32'h102, 32'd0, 4'h0, "rd_misaligned");
        txn(1'b0, 32'h400, 32'd0, 4'h0, "rd_out_of_range");
        txn(1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, "wr_misaligned");
        txn(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, "wr_out_of_range");
        txn(1'b0, 32'h100, 32'd0, 4'h0, "rd_100_after_bad");
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL bad_wr_untouched got=%h exp=deadbeef", last_rdata);
        end
        txn(1'b0, 32'h0, 32'd0, 4'h0, "rd_0_after_bad");
    endtask

    task automatic test_be_zero();
        txn(1'b1, 32'h40, 32'h0, 4'h0, "wr_be0");
        txn(1'b0, 32'h40, 32'd0, 4'h0, "rd_be0");
        checks++;
        if (last_rdata !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL be0_noop got=%h exp=11bb33dd", last_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int t = 0; t < 80; t++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            r = $urandom_range(0, 9);
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = a | (32'h1 << $urandom_range(10, 31));
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "random");
        end
    endtask

    // req held high: accepts every LATENCY+2 cycles on the latency-2 responder.
    task automatic test_back_to_back();
        en = 3'b001;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h100; wdata = 32'd0; be = 4'h0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 16; n++) begin
            checks++;
            if (ready_v[0] !== ((n % 4) == 2)) begin
                failures++;
                $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", n, ready_v[0], ((n % 4) == 2));
            end
            checks++;
            if (busy_v[0] !== ((n % 4) != 3)) begin
                failures++;
                $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", n, busy_v[0], ((n % 4) != 3));
            end
            if (ready_v[0] === 1'b1) begin
                checks++;
                if (rdata_v[0] !== model[8'h40]) begin
                    failures++;
                    $display("FAIL b2b_data got=%h exp=%h", rdata_v[0], model[8'h40]);
                end
            end
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        repeat (5) @(posedge clk);
        en = 3'b111;
    endtask

    task automatic test_reset_mid();
        logic [31:0] prior;
        en = 3'b101;
        prior = model[8'h02];
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h55; be = 4'hF;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle_zero("reset_mid");
        @(posedge clk);
        #1;
        check_idle_zero("reset_mid_held");
        @(negedge clk);
        rst = 1'b0;
        en = 3'b111;
        txn(1'b0, 32'h8, 32'd0, 4'h0, "rd_8_after_reset");
        checks++;
        if (last_rdata !== prior) begin
            failures++;
            $display("FAIL abandoned_write got=%h exp=%h", last_rdata, prior);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_bad_access();
        test_be_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
